ram_stream_reader: RTL and testbench

- Drives the read port of a two-port RAM (rd, adr, clk_en; read latency 1 or 2 cycles) and streams a contiguous address range out over a valid/ready interface.
- Typical use: draining a frame or line buffer into the video/output path while the compute side fills the write port.
- Absorbs RAM read latency and downstream backpressure with an internal 8-entry FIFO and credit counter, so no word is lost or duplicated.

---
 rtl/ram_stream_reader_if.sv | 24 ++
 rtl/ram_stream_reader.sv | 135 +++++++++++++
 tb/tb_ram_stream_reader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// Downstream word stream: valid/ready handshake carrying data
// and an end-of-transfer mark.
interface ram_stream_reader_if #(
  parameter int DW = 8
);
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_dat;
  logic          out_last;

  modport master (
    output out_vld,
    output out_dat,
    output out_last,
    input  out_rdy
  );

  modport slave (
    input  out_vld,
    input  out_dat,
    input  out_last,
    output out_rdy
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams a contiguous RAM address range over valid/ready, hiding
// read latency and backpressure behind an 8-deep credit FIFO.
module ram_stream_reader #(
  parameter int DW = 8,
  parameter int MD = 1024,
  parameter int AW = $clog2(MD),
  parameter bit READ_REGISTERED = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          ram_clk_en,
  output logic          ram_rd,
  output logic [AW-1:0] ram_adr,
  input  logic [DW-1:0] ram_dat,
  ram_stream_reader_if.master dn
);
  localparam int LAT = 1 + int'(READ_REGISTERED);
  localparam logic [3:0] FD = 4'd8;
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW-1:0] ATOP = AW'(MD - 1);
  localparam logic [AW-1:0] AONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [AW-1:0]  adr;
  logic [AW-1:0]  adr_nxt;
  logic [AW-1:0]  adr_inc;
  logic [AW:0]    rem;
  logic [AW:0]    rem_nxt;
  logic [3:0]     credit;
  logic [3:0]     credit_nxt;
  logic           issue;
  logic           is_last;
  logic           push;
  logic           pop;
  logic           vld;
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_l;
  logic [DW:0]    fifo [8];
  logic [DW:0]    head;
  logic [2:0]     wp;
  logic [2:0]     rp;
  logic [3:0]     cnt;

  assign is_last = (rem == ONE);
  assign issue = (state == S_READ)
               && (rem != '0)
               && (credit < FD);
  assign adr_inc = (adr == ATOP) ? '0 : adr + AONE;

  // read tags emerge exactly when the RAM presents their data
  assign push = tag_v[LAT-1];
  assign vld = (cnt != 4'd0);
  assign pop = vld && dn.out_rdy;
  assign credit_nxt = credit + 4'(issue) - 4'(pop);
  assign head = fifo[rp];

  always_comb begin
    state_nxt = state;
    adr_nxt = adr;
    rem_nxt = rem;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          adr_nxt = base;
          rem_nxt = len;
          state_nxt = (len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          adr_nxt = adr_inc;
          rem_nxt = rem - ONE;
          if (is_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // leave as the final word is taken so done follows it directly
        if (credit_nxt == 4'd0) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      adr <= '0;
      rem <= '0;
      credit <= '0;
      tag_v <= '0;
      tag_l <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      adr <= adr_nxt;
      rem <= rem_nxt;
      credit <= credit_nxt;
      tag_v <= LAT'({tag_v, issue});
      tag_l <= LAT'({tag_l, issue && is_last});
      if (push) wp <= wp + 3'd1;
      if (pop) rp <= rp + 3'd1;
      cnt <= cnt + 4'(push) - 4'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= {tag_l[LAT-1], ram_dat};
  end

  assign busy = !rst && (state != S_IDLE);
  assign done = !rst && (state == S_DONE);
  assign ram_clk_en = !rst;
  assign ram_rd = !rst && issue;
  assign ram_adr = rst ? '0 : adr;

  assign dn.out_vld = !rst && vld;
  assign dn.out_dat = dn.out_vld ? head[DW-1:0] : '0;
  assign dn.out_last = dn.out_vld && head[DW];
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench: two readers (latency 1 and 2) on one stimulus, checked
// against address/word/timing expectations derived from the transfer.
module tb_ram_stream_reader;
  localparam int DW = 8;
  localparam int MD = 300;
  localparam int AW = $clog2(MD);
  localparam int NL = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_rdy = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;

  logic          busy_a [2];
  logic          done_a [2];
  logic          cen_a [2];
  logic          rd_a [2];
  logic [AW-1:0] adr_a [2];
  logic [DW-1:0] rdat_a [2];
  logic          vld_a [2];
  logic          last_a [2];
  logic [DW-1:0] dat_a [2];

  logic [DW-1:0] mem [MD];
  logic [DW-1:0] q0;
  logic [DW-1:0] q1a;
  logic [DW-1:0] q1b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int got_w [2][NL];
  int got_c [2][NL];
  int adr_l [2][NL];
  int got_n [2];
  int rd_n [2];
  int outs [2];
  int max_outs [2];
  int rd_full [2];
  int stall_err [2];
  int done_n [2];
  int done_c [2];
  bit stall_p [2];
  int stall_v [2];

  always #5 clk = ~clk;

  ram_stream_reader_if #(.DW(DW)) s0 ();
  ram_stream_reader_if #(.DW(DW)) s1 ();

  assign s0.out_rdy = out_rdy;
  assign s1.out_rdy = out_rdy;
  assign vld_a[0] = s0.out_vld;
  assign vld_a[1] = s1.out_vld;
  assign last_a[0] = s0.out_last;
  assign last_a[1] = s1.out_last;
  assign dat_a[0] = s0.out_dat;
  assign dat_a[1] = s1.out_dat;

  ram_stream_reader #(
    .DW(DW), .MD(MD), .READ_REGISTERED(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .base(base), .len(len),
    .busy(busy_a[0]), .done(done_a[0]),
    .ram_clk_en(cen_a[0]), .ram_rd(rd_a[0]),
    .ram_adr(adr_a[0]), .ram_dat(rdat_a[0]),
    .dn(s0)
  );

  ram_stream_reader #(
    .DW(DW), .MD(MD), .READ_REGISTERED(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .base(base), .len(len),
    .busy(busy_a[1]), .done(done_a[1]),
    .ram_clk_en(cen_a[1]), .ram_rd(rd_a[1]),
    .ram_adr(adr_a[1]), .ram_dat(rdat_a[1]),
    .dn(s1)
  );

  // RAM read ports: one and two cycles of latency
  always @(posedge clk) begin
    if (cen_a[0] && rd_a[0]) q0 <= mem[adr_a[0]];
    if (cen_a[1] && rd_a[1]) q1a <= mem[adr_a[1]];
    if (cen_a[1]) q1b <= q1a;
  end
  assign rdat_a[0] = q0;
  assign rdat_a[1] = q1b;

  always @(posedge clk) cyc <= cyc + 1;

  // observed stream: words, read addresses, outstanding reads, stalls
  always @(negedge clk) begin
    int w;
    for (int k = 0; k < 2; k++) begin
      w = int'({last_a[k], dat_a[k]});
      if (rst) begin
        outs[k] = 0;
        stall_p[k] = 1'b0;
      end else begin
        if (rd_a[k]) begin
          if (outs[k] >= 8) rd_full[k]++;
          if (rd_n[k] < NL) adr_l[k][rd_n[k]] = int'(adr_a[k]);
          rd_n[k]++;
          outs[k]++;
        end
        if (stall_p[k] && (!vld_a[k] || stall_v[k] != w))
          stall_err[k]++;
        if (vld_a[k] && out_rdy) begin
          if (got_n[k] < NL) begin
            got_w[k][got_n[k]] = w;
            got_c[k][got_n[k]] = cyc;
          end
          got_n[k]++;
          outs[k]--;
        end
        stall_p[k] = vld_a[k] && !out_rdy;
        stall_v[k] = w;
        if (outs[k] > max_outs[k]) max_outs[k] = outs[k];
        if (done_a[k]) begin
          done_n[k]++;
          done_c[k] = cyc;
        end
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic rnd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic run_xfer(input string tag, input int b, input int l,
                          input int pct, input int poke);
    int g0 [2];
    int r0 [2];
    int d0 [2];
    int c0;
    int n;
    int m;
    int bad;
    int lat;
    int a;
    int e;
    for (int k = 0; k < 2; k++) begin
      g0[k] = got_n[k];
      r0[k] = rd_n[k];
      d0[k] = done_n[k];
    end
    @(posedge clk);
    #1;
    base = AW'(b);
    len = (AW + 1)'(l);
    start = 1'b1;
    c0 = cyc;
    out_rdy = rnd(pct);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      start = (n == poke);
      if (n == poke) base = AW'((b + 37) % MD);
      out_rdy = rnd(pct);
    end while ((done_n[0] == d0[0] || done_n[1] == d0[1]) && n < 3000);
    chk({tag, "_timeout"}, int'(n < 3000), 1);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      out_rdy = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      lat = 1 + k;
      chk($sformatf("%s_k%0d_words", tag, k), got_n[k] - g0[k], l);
      chk($sformatf("%s_k%0d_reads", tag, k), rd_n[k] - r0[k], l);
      chk($sformatf("%s_k%0d_done", tag, k), done_n[k] - d0[k], 1);
      chk($sformatf("%s_k%0d_busy", tag, k), int'(busy_a[k]), 0);
      m = l;
      if (got_n[k] - g0[k] < m) m = got_n[k] - g0[k];
      if (rd_n[k] - r0[k] < m) m = rd_n[k] - r0[k];
      bad = 0;
      for (int i = 0; i < m; i++) begin
        a = (b + i) % MD;
        e = int'(mem[a]) + ((i == l - 1) ? (1 << DW) : 0);
        if (got_w[k][g0[k] + i] != e) bad++;
        if (adr_l[k][r0[k] + i] != a) bad++;
        if (pct == 100 && got_c[k][g0[k] + i] - c0 != 2 + lat + i)
          bad++;
      end
      chk($sformatf("%s_k%0d_stream", tag, k), bad, 0);
      if (pct == 100)
        chk($sformatf("%s_k%0d_donecyc", tag, k), done_c[k] - c0,
            (l == 0) ? 1 : 2 + lat + l);
    end
  endtask

  initial begin
    int d0 [2];
    int g0 [2];
    for (int i = 0; i < MD; i++) mem[i] = DW'(i);

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_k%0d_busy", k), int'(busy_a[k]), 0);
      chk($sformatf("rst_k%0d_done", k), int'(done_a[k]), 0);
      chk($sformatf("rst_k%0d_rd", k), int'(rd_a[k]), 0);
      chk($sformatf("rst_k%0d_adr", k), int'(adr_a[k]), 0);
      chk($sformatf("rst_k%0d_vld", k), int'(vld_a[k]), 0);
      chk($sformatf("rst_k%0d_last", k), int'(last_a[k]), 0);
      chk($sformatf("rst_k%0d_dat", k), int'(dat_a[k]), 0);
      chk($sformatf("rst_k%0d_cen", k), int'(cen_a[k]), 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("idle_k%0d_cen", k), int'(cen_a[k]), 1);

    run_xfer("basic", 10, 4, 100, 0);
    run_xfer("burst64", 5, 64, 100, 0);
    for (int i = 0; i < MD; i++) mem[i] = DW'($urandom);
    run_xfer("bp200", $urandom_range(MD - 1), 200, 30, 0);
    run_xfer("wrap", MD - 2, 4, 100, 0);
    run_xfer("len0", 7, 0, 100, 0);
    run_xfer("busy_start", 20, 8, 100, 3);
    run_xfer("bp_rand", $urandom_range(MD - 1),
             $urandom_range(MD, 1), 50, 0);

    for (int k = 0; k < 2; k++) begin
      d0[k] = done_n[k];
      g0[k] = got_n[k];
    end
    @(posedge clk);
    #1;
    base = '0;
    len = (AW + 1)'(32);
    start = 1'b1;
    out_rdy = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_fifo_full", int'(vld_a[1]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort_k%0d_vld", k), int'(vld_a[k]), 0);
      chk($sformatf("abort_k%0d_busy", k), int'(busy_a[k]), 0);
    end
    out_rdy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort_k%0d_nodone", k), done_n[k] - d0[k], 0);
      chk($sformatf("abort_k%0d_nowords", k), got_n[k] - g0[k], 0);
    end
    run_xfer("post_rst", 0, 2, 100, 0);

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d_credit_peak", k), max_outs[k], 8);
      chk($sformatf("k%0d_rd_at_full", k), rd_full[k], 0);
      chk($sformatf("k%0d_stall_hold", k), stall_err[k], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
